// File: rtl/fifo_spi_master.sv
// FIFO SPI link initiator: clocks one 16-bit word out of the remote
// responder per rd_req and hands it over with a one-cycle rd_valid.
module fifo_spi_master #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 8,
  parameter int CS_IDLE  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rd_req,
  output logic        rd_busy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        fifo_clk,
  output logic        fifo_cs,
  output logic        fifo_mosi,
  input  logic        fifo_miso
);

  localparam int DMAX = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int DW   = $clog2(DMAX);
  localparam int IW   = $clog2(CS_IDLE);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOW, HIGH, HOLD
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [DW-1:0] div_cnt;
  logic [IW-1:0] idle_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic [1:0]  miso_sync;
  logic        div_done;
  logic        idle_done;
  logic        cs_d;
  logic        clk_d;
  logic        busy_d;
  logic        valid_d;

  assign div_done  = (div_cnt == '0);
  assign idle_done = (idle_cnt == '0);
  assign fifo_mosi = 1'b0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (rd_req && idle_done) state_nx = SETUP;
      SETUP: if (div_done) state_nx = LOW;
      LOW:   if (div_done) state_nx = HIGH;
      HIGH:  if (div_done)
               state_nx = (bit_cnt == 4'd15) ? HOLD : LOW;
      HOLD:  if (div_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pins are flops.
  always_comb begin
    cs_d    = (state_nx == IDLE);
    clk_d   = (state_nx == HIGH);
    busy_d  = (state_nx != IDLE);
    valid_d = (state == HOLD) && (state_nx == IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fifo_cs   <= 1'b1;
      fifo_clk  <= 1'b0;
      rd_busy   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      div_cnt   <= '0;
      idle_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      miso_sync <= '0;
    end else begin
      fifo_cs   <= cs_d;
      fifo_clk  <= clk_d;
      rd_busy   <= busy_d;
      rd_valid  <= valid_d;
      miso_sync <= {miso_sync[0], fifo_miso};
      if (valid_d) rd_data <= shreg;

      if (state != state_nx)
        div_cnt <= (state_nx == SETUP) ? DW'(CS_SETUP - 1)
                                       : DW'(CLK_DIV - 1);
      else if (!div_done)
        div_cnt <= div_cnt - 1'b1;

      if (state == SETUP && div_done)
        bit_cnt <= '0;
      else if (state == HIGH && div_done && bit_cnt != 4'd15)
        bit_cnt <= bit_cnt + 1'b1;

      if (state == LOW && div_done)
        shreg <= {shreg[14:0], miso_sync[1]};

      // Reload one short: the valid cycle itself is the first idle cycle.
      if (valid_d)
        idle_cnt <= IW'(CS_IDLE - 1);
      else if (state == IDLE && !idle_done)
        idle_cnt <= idle_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_spi_master.sv
// Directed bench for fifo_spi_master with a synchronising responder
// model; instance 0 uses CS_SETUP=8, instance 1 the minimum 6.
module tb_fifo_spi_master;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        rd_req [2];
  logic [15:0] word   [2];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int SETUP = (g == 0) ? 8 : 6;
    logic        rd_busy, rd_valid, fifo_clk, fifo_cs;
    logic        fifo_mosi, fifo_miso;
    logic [15:0] rd_data;

    fifo_spi_master #(
      .CLK_DIV(4), .CS_SETUP(SETUP), .CS_IDLE(4)
    ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .rd_req   (rd_req[g]),
      .rd_busy  (rd_busy),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .fifo_clk (fifo_clk),
      .fifo_cs  (fifo_cs),
      .fifo_mosi(fifo_mosi),
      .fifo_miso(fifo_miso)
    );

    // Responder: both pins cross two flops before edge detection.
    logic [2:0]  cs_s = 3'b111;
    logic [2:0]  ck_s = 3'b000;
    logic [15:0] sr   = 16'h0000;
    always_ff @(posedge sys_clk) begin
      cs_s <= {cs_s[1:0], fifo_cs};
      ck_s <= {ck_s[1:0], fifo_clk};
      if (cs_s[2:1] == 2'b10)      sr <= word[g];
      else if (ck_s[2:1] == 2'b01) sr <= {sr[14:0], 1'b0};
    end
    assign fifo_miso = sr[15];

    int          cs_lo = 0, cs_hi = 0, rises = 0;
    int          last_lo = 0, last_gap = 0, last_rises = 0;
    int          nvalid = 0;
    logic        cs_p = 1'b1, ck_p = 1'b0;
    logic [15:0] last_data = 16'h0;
    logic        valid_ok = 1'b0;
    always @(negedge sys_clk) begin
      if (fifo_clk && !ck_p) rises++;
      if (!fifo_cs && cs_p) begin
        last_gap = cs_hi;
        rises    = 0;
        cs_lo    = 0;
      end
      if (fifo_cs && !cs_p) begin
        last_lo    = cs_lo;
        last_rises = rises;
        cs_hi      = 0;
      end
      if (fifo_cs) cs_hi++;
      else         cs_lo++;
      if (rd_valid) begin
        nvalid++;
        last_data = rd_data;
        valid_ok  = fifo_cs && !cs_p && !rd_busy;
      end
      cs_p = fifo_cs;
      ck_p = fifo_clk;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse0();
    rd_req[0] = 1'b1;
    cyc(1);
    rd_req[0] = 1'b0;
  endtask

  task automatic wait_v0(input string tag, input int nv);
    int k = 0;
    while (g_inst[0].nvalid == nv && k < 500) begin
      cyc(1);
      k++;
    end
    check({tag, "_done"}, g_inst[0].nvalid, nv + 1);
  endtask

  logic [15:0] pats [4] = '{16'h0000, 16'hFFFF, 16'h8001, 16'h7FFE};
  logic [15:0] b2b  [3] = '{16'h1234, 16'h5678, 16'h9ABC};

  initial begin
    int nv;
    int k;
    sys_rst   = 1'b1;
    rd_req[0] = 1'b0;
    rd_req[1] = 1'b0;
    word[0]   = 16'h0;
    word[1]   = 16'h0;
    cyc(3);
    check("rst_cs",    g_inst[0].fifo_cs,   1);
    check("rst_clk",   g_inst[0].fifo_clk,  0);
    check("rst_mosi",  g_inst[0].fifo_mosi, 0);
    check("rst_busy",  g_inst[0].rd_busy,   0);
    check("rst_valid", g_inst[0].rd_valid,  0);
    check("rst_data",  g_inst[0].rd_data,   0);
    sys_rst = 1'b0;
    cyc(2);

    nv      = g_inst[0].nvalid;
    word[0] = 16'hA5C3;
    pulse0();
    check("single_busy", g_inst[0].rd_busy, 1);
    wait_v0("single", nv);
    check("single_cs_low", g_inst[0].last_lo,    140);
    check("single_rises",  g_inst[0].last_rises, 16);
    check("single_data",   g_inst[0].last_data,  16'hA5C3);
    check("single_align",  g_inst[0].valid_ok,   1);
    cyc(1);
    check("single_strobe", g_inst[0].rd_valid, 0);
    check("single_hold",   g_inst[0].rd_data,  16'hA5C3);
    cyc(6);

    for (int i = 0; i < 4; i++) begin
      nv      = g_inst[0].nvalid;
      word[0] = pats[i];
      pulse0();
      wait_v0("pat", nv);
      check("pat_data", g_inst[0].last_data, pats[i]);
      cyc(6);
    end

    word[0]   = b2b[0];
    rd_req[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nv = g_inst[0].nvalid;
      wait_v0("b2b", nv);
      check("b2b_data", g_inst[0].last_data, b2b[i]);
      if (i > 0) check("b2b_gap", g_inst[0].last_gap, 4);
      if (i < 2) word[0] = b2b[i + 1];
      else       rd_req[0] = 1'b0;
    end
    cyc(6);

    nv      = g_inst[0].nvalid;
    word[0] = 16'h3C3C;
    pulse0();
    cyc(20);
    check("busy_mid", g_inst[0].rd_busy, 1);
    pulse0();
    wait_v0("busy", nv);
    check("busy_data", g_inst[0].last_data, 16'h3C3C);
    cyc(40);
    check("busy_once",  g_inst[0].nvalid,  nv + 1);
    check("busy_cs",    g_inst[0].fifo_cs, 1);
    check("busy_cs_hi", g_inst[0].cs_hi,   41);

    nv      = g_inst[0].nvalid;
    word[0] = 16'hFFFF;
    pulse0();
    k = 0;
    while (g_inst[0].rises != 7 && k < 300) begin
      cyc(1);
      k++;
    end
    check("rst_rise7", g_inst[0].rises, 7);
    sys_rst = 1'b1;
    cyc(1);
    sys_rst = 1'b0;
    check("midrst_cs",   g_inst[0].fifo_cs,  1);
    check("midrst_clk",  g_inst[0].fifo_clk, 0);
    check("midrst_data", g_inst[0].rd_data,  0);
    check("midrst_busy", g_inst[0].rd_busy,  0);
    cyc(40);
    check("midrst_novalid", g_inst[0].nvalid, nv);
    word[0] = 16'h0F0F;
    pulse0();
    wait_v0("after_rst", nv);
    check("after_rst_data", g_inst[0].last_data, 16'h0F0F);
    cyc(6);

    for (int i = 0; i < 100; i++) begin
      nv        = g_inst[1].nvalid;
      word[1]   = 16'($urandom);
      rd_req[1] = 1'b1;
      cyc(1);
      rd_req[1] = 1'b0;
      k = 0;
      while (g_inst[1].nvalid == nv && k < 400) begin
        cyc(1);
        k++;
      end
      check("min_done", g_inst[1].nvalid,    nv + 1);
      check("min_data", g_inst[1].last_data, word[1]);
      check("min_cs_low", g_inst[1].last_lo, 138);
      cyc(5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
